mult_acc_ctrl: RTL and testbench



---
 rtl/mult_acc_ctrl.sv | 116 +++++++++++
 tb/tb_mult_acc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc_ctrl.sv
// Frame dot-product sequencer around an external 8x8 combinational multiplier.
// Define MAC_SAT_EN to make the accumulator saturate instead of wrapping.
module mult_acc_ctrl #(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  input  logic [15:0]      mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCUM, FINAL, HOLD} state_t;

  state_t             state, state_nxt;
  logic               rdy_en;
  logic               op_vld, op_last;
  logic [ACC_W-1:0]   acc, acc_add;
  logic [CNT_W-1:0]   cnt, cnt_inc;
  logic               ovf, carry, take;
  logic [ACC_W:0]     sum_ext;

  // rdy_en keeps in_ready low until the first edge after reset release
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = rdy_en;
        if (in_valid && rdy_en && in_last) state_nxt = FINAL;
      end
      FINAL:   state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
    if (clr) state_nxt = ACCUM;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  assign take    = in_valid && in_ready && !clr;
  assign sum_ext = {1'b0, acc} + {{(ACC_W-15){1'b0}}, mul_p};
  assign carry   = sum_ext[ACC_W];
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);

`ifdef MAC_SAT_EN
  assign acc_add = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en    <= 1'b0;
      mul_a     <= '0;
      mul_b     <= '0;
      op_vld    <= 1'b0;
      op_last   <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (clr) begin
        op_vld    <= 1'b0;
        op_last   <= 1'b0;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
        out_valid <= 1'b0;
      end else begin
        op_vld <= take;
        if (take) begin
          mul_a   <= in_a;
          mul_b   <= in_b;
          op_last <= in_last;
        end
        // last product is folded straight into the result, not into acc
        if (op_vld && op_last) begin
          out_sum   <= acc_add;
          out_count <= cnt_inc;
          out_ovf   <= ovf | carry;
          out_valid <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          ovf       <= 1'b0;
        end else if (op_vld) begin
          acc <= acc_add;
          cnt <= cnt_inc;
          ovf <= ovf | carry;
        end
        if (state == HOLD && out_ready) out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_acc_ctrl.sv
// Bench for mult_acc_ctrl: frame-level model plus directed frames on 24- and 16-bit instances.
module tb_mult_acc_ctrl;
  logic clk = 0, rst_n = 0, clr = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [7:0] in_a = 0, in_b = 0;

  logic        in_ready, out_valid, out_ovf;
  logic [7:0]  mul_a, mul_b, out_count;
  logic [15:0] mul_p;
  logic [23:0] out_sum;

  logic        s_in_ready, s_out_valid, s_out_ovf;
  logic [7:0]  s_mul_a, s_mul_b, s_out_count;
  logic [15:0] s_mul_p, s_out_sum;

  assign mul_p   = mul_a * mul_b;
  assign s_mul_p = s_mul_a * s_mul_b;

  mult_acc_ctrl #(.ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .out_ovf(out_ovf));

  mult_acc_ctrl #(.ACC_W(16), .CNT_W(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_a(s_mul_a), .mul_b(s_mul_b),
    .mul_p(s_mul_p), .out_valid(s_out_valid), .out_ready(out_ready), .out_sum(s_out_sum),
    .out_count(s_out_count), .out_ovf(s_out_ovf));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame result from the true (unbounded) sum of products.
  function automatic longint res(input longint t, input int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef MAC_SAT_EN
    return (t >= lim) ? lim - 1 : t;
`else
    return t % lim;
`endif
  endfunction

  // Model: frame accumulated as a plain integer; result published one edge after the last beat.
  bit         m_rdy = 0, m_ov = 0, pend = 0, m_take = 0;
  logic [7:0] m_a = 0, m_b = 0;
  longint     fr_sum = 0, e_sum24 = 0, e_sum16 = 0, e_cnt = 0;
  int         fr_cnt = 0;
  bit         e_ovf24 = 0, e_ovf16 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy = 0; m_ov = 0; pend = 0; m_a = 0; m_b = 0;
      fr_sum = 0; fr_cnt = 0;
    end else begin
      m_take = in_valid && m_rdy && !clr;
      if (clr) begin
        fr_sum = 0; fr_cnt = 0; pend = 0; m_ov = 0; m_rdy = 1;
      end else begin
        if (pend) begin
          e_sum24 = res(fr_sum, 24);
          e_sum16 = res(fr_sum, 16);
          e_ovf24 = fr_sum >= (longint'(1) << 24);
          e_ovf16 = fr_sum >= (longint'(1) << 16);
          e_cnt   = (fr_cnt > 255) ? 255 : fr_cnt;
          m_ov = 1; pend = 0; fr_sum = 0; fr_cnt = 0; m_rdy = 0;
        end else if (m_ov && out_ready) begin
          m_ov = 0; m_rdy = 1;
        end else if (!m_ov) begin
          m_rdy = 1;
        end
        if (m_take) begin
          m_a = in_a; m_b = in_b;
          fr_sum += longint'(in_a) * longint'(in_b);
          fr_cnt++;
          if (in_last) begin pend = 1; m_rdy = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("in_ready16", s_in_ready, m_rdy);
    chk("out_valid", out_valid, m_ov);
    chk("out_valid16", s_out_valid, m_ov);
    chk("mul_a", mul_a, m_a);
    chk("mul_b", mul_b, m_b);
    chk("mul_a16", s_mul_a, m_a);
    if (m_ov) begin
      chk("out_sum", out_sum, e_sum24);
      chk("out_count", out_count, e_cnt);
      chk("out_ovf", out_ovf, e_ovf24);
      chk("out_sum16", s_out_sum, e_sum16);
      chk("out_count16", s_out_count, e_cnt);
      chk("out_ovf16", s_out_ovf, e_ovf16);
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input bit last);
    bit got;
    got = 0;
    in_a = a; in_b = b; in_last = last; in_valid = 1;
    for (int k = 0; k < 40 && !got; k++) begin
      got = in_ready;
      step();
    end
    if (!got) chk("send_timeout", 0, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_out(input int lim);
    int k;
    k = 0;
    while (!out_valid && k < lim) begin step(); k++; end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic ack();
    out_ready = 1; step(); out_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_out_sum", out_sum, 0);
    repeat (2) step();
    rst_n = 1;
    chk("ready_pre", in_ready, 0);
    step();
    chk("ready_post", in_ready, 1);

    // back-to-back three-beat frame
    send(100, 23, 0); send(255, 255, 0); send(1, 1, 1);
    chk("t1_lat_pre", out_valid, 0);
    step();
    chk("t1_lat", out_valid, 1);
    chk("t1_sum", out_sum, 67326);
    chk("t1_cnt", out_count, 3);
    chk("t1_ovf", out_ovf, 0);
    ack();

    // single-beat frame
    send(100, 23, 1);
    chk("t2_rdy_final", in_ready, 0);
    step();
    chk("t2_vld", out_valid, 1);
    chk("t2_sum", out_sum, 2300);
    chk("t2_cnt", out_count, 1);
    chk("t2_rdy_hold", in_ready, 0);
    ack();
    chk("t2_rdy_after", in_ready, 1);

    // 16-bit carry-out frame
    send(255, 255, 0); send(255, 255, 1);
    wait_out(4);
`ifdef MAC_SAT_EN
    chk("t3_sum16", s_out_sum, 65535);
`else
    chk("t3_sum16", s_out_sum, 64514);
`endif
    chk("t3_ovf16", s_out_ovf, 1);
    chk("t3_sum24", out_sum, 130050);
    chk("t3_ovf24", out_ovf, 0);

    // backpressure with a beat offered during HOLD
    in_a = 9; in_b = 9; in_last = 1; in_valid = 1;
    repeat (5) begin
      step();
      chk("t4_rdy", in_ready, 0);
      chk("t4_vld", out_valid, 1);
      chk("t4_sum", out_sum, 130050);
      chk("t4_mul_a", mul_a, 255);
    end
    in_valid = 0; in_last = 0;
    ack();
    chk("t4_vld_after", out_valid, 0);
    chk("t4_rdy_after", in_ready, 1);

    // abort mid-frame, dropped beat alongside clr
    send(10, 10, 0); send(20, 20, 0);
    clr = 1; in_valid = 1; in_a = 5; in_b = 5; in_last = 1;
    step();
    clr = 0; in_valid = 0; in_last = 0;
    send(3, 3, 1);
    wait_out(4);
    chk("t5_sum", out_sum, 9);
    chk("t5_cnt", out_count, 1);
    ack();

    // long frame: count saturates
    for (int i = 0; i < 300; i++) send(1, 1, i == 299);
    wait_out(4);
    chk("t6_cnt_sat", out_count, 255);
    chk("t6_sum", out_sum, 300);
    ack();

    // asynchronous reset between edges, mid-frame
    send(7, 7, 0);
    #1 rst_n = 0;
    #1;
    chk("t7_rdy", in_ready, 0);
    chk("t7_vld", out_valid, 0);
    chk("t7_mul_a", mul_a, 0);
    chk("t7_sum", out_sum, 0);
    chk("t7_cnt", out_count, 0);
    step(); step();
    rst_n = 1;
    step();
    send(7, 8, 1);
    wait_out(4);
    chk("t7_sum_after", out_sum, 56);
    chk("t7_cnt_after", out_count, 1);
    ack();

    repeat (2) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
